ddr3_ctrl_bram_model: RTL and testbench
=======================================

// Module: ddr3_ctrl_bram_model
// PURPOSE
//  Responder side of the ddr3_controller user interface (rd/wr/refresh/addr/din -> dout/data_ready/busy),
//  backed by on-chip block RAM instead of DDR3 PHY. Drop-in stand-in for the real controller so memory
//  clients and the memory self-test FSM run in sim and on boards without DDR3. Timing is parameterised,
//  with read-data error injection to exercise client failure paths.
// PARAMETERS
//  ADDR_WIDTH    16  words backed = 2**ADDR_WIDTH; addr[25:ADDR_WIDTH] ignored (aliases)
//  READ_LATENCY  2   edges from rd acceptance to dout/data_ready registered; legal >= 2
//  WRITE_BUSY    2   busy cycles after wr acceptance; legal >= 1
//  REFRESH_BUSY  6   busy cycles after refresh acceptance; legal >= 1
//  INIT_CYCLES   16  cycles after reset release before first command is accepted; legal >= 1
// PORTS
//  clk         in   1   clock
//  resetn      in   1   reset, synchronous, active-low
//  rd          in   1   read command pulse
//  wr          in   1   write command pulse
//  refresh     in   1   refresh command pulse
//  addr        in   26  word address
//  din         in   16  write data
//  inject      in   2   [1]: XOR dout[15:8] with 8'h01, [0]: XOR dout[7:0] with 8'h01 (sampled at rd accept)
//  dout        out  16  read data, held until next read completes
//  data_ready  out  1   one-cycle pulse, dout valid
//  busy        out  1   high during init and while a command is in progress
//  init_done   out  1   high once INIT_CYCLES elapsed
//  cmd_err     out  1   sticky: command dropped (busy, init, or collision)
// BEHAVIOUR
//  Reset (resetn=0 at edge): state=INIT, counter cleared, busy=1, init_done=0, data_ready=0, dout=0,
//   cmd_err=0, read pipeline flushed. RAM contents NOT cleared. Reset mid-command aborts it (no data_ready).
//  FSM: INIT -> IDLE after INIT_CYCLES edges (busy=0, init_done=1 registered same edge).
//   IDLE: command sampled at edge N -> busy=1 registered at N; WRITE/READ/REFRESH state.
//   WRITE: mem[addr[ADDR_WIDTH-1:0]] <= din at edge N; busy high WRITE_BUSY cycles, then IDLE.
//   READ: RAM read registered at N+1, delay line to N+READ_LATENCY; at that edge dout=data^inject mask,
//    data_ready=1 for exactly one cycle; busy high READ_LATENCY cycles (falls same edge data_ready rises).
//   REFRESH: no RAM access; busy high REFRESH_BUSY cycles, then IDLE.
//  Busy count K means busy=1 on edges N..N+K-1, 0 from N+K; next command acceptable at edge N+K.
//  Collision (>1 of rd/wr/refresh same cycle in IDLE): priority wr > rd > refresh; winner executes,
//   others dropped, cmd_err set.
//  Any command while busy=1 (INIT or active): ignored, cmd_err set. No queueing.
//  Read-after-write same address returns new data (write committed at N, read issued >= N+1).
//  Counter width $clog2(max(INIT_CYCLES,WRITE_BUSY,READ_LATENCY,REFRESH_BUSY)+1); no wrap.
//  inject applies only to the read accepted while it is sampled; RAM never corrupted.
// STRUCTURE
//  Package ddr3_pkg: localparam DDR3_ADDR_W=26, DDR3_DATA_W=16; typedef enum state_t
//   {INIT,IDLE,READ,WRITE,REFRESH}; typedef struct cmd_t {rd,wr,refresh}.
//  Sub-module ddr3_bram_sp: single-port 2**ADDR_WIDTH x 16 RAM, sync write, registered read,
//   written to infer block RAM. Top holds FSM, busy counter, read delay line, error logic.
// TESTING
//  1 Release resetn; rd at cycle 5 -> busy=1 for 16 cycles, init_done rises cycle 16, rd ignored, cmd_err=1.
//  2 wr addr 0x0005 din 0x67B9; after busy low, rd 0x0005 -> busy 2 cycles, data_ready one cycle at N+2,
//    dout=0x67B9 and held until next read.
//  3 wr addr 26'h001_0003 din 0xA5A5; rd 26'h000_0003 -> dout=0xA5A5 (upper bits aliased).
//  4 rd+wr same cycle, addr 0x0010 din 0x1111 -> mem[0x10]=0x1111, no data_ready, cmd_err=1.
//  5 mem[0x20]=0x1234; rd with inject=2'b10 -> dout=0x1334; rd again inject=0 -> 0x1234.
//  6 refresh -> busy 6 cycles; wr during cycle 3 ignored (mem unchanged), cmd_err=1;
//    assert resetn=0 mid-read -> no data_ready, re-init, prior RAM contents read back intact.

Source files
------------

// File: rtl/ddr3_ctrl_bram_model_pkg.sv
// Shared types for the BRAM-backed DDR3 controller stand-in.
// Command bundle, FSM states and read-error injection mask.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 26;
  localparam int DDR3_DATA_W = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    WRITE,
    REFRESH
  } state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic refresh;
  } cmd_t;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Each inject bit flips the LSB of its byte lane.
  function automatic logic [DDR3_DATA_W-1:0] inj_mask(
    input logic [1:0] inj
  );
    return {7'b0, inj[1], 7'b0, inj[0]};
  endfunction

endpackage

// File: rtl/ddr3_ctrl_bram_model_if.sv
// User-side command/data bundle of the DDR3 controller.
// master = memory client, slave = controller (or this model).
interface ddr3_ctrl_bram_model_if
  import ddr3_pkg::*;
();

  logic                   rd;
  logic                   wr;
  logic                   refresh;
  logic [DDR3_ADDR_W-1:0] addr;
  logic [DDR3_DATA_W-1:0] din;
  logic [1:0]             inject;
  logic [DDR3_DATA_W-1:0] dout;
  logic                   data_ready;
  logic                   busy;
  logic                   init_done;
  logic                   cmd_err;

  modport master (
    output rd,
    output wr,
    output refresh,
    output addr,
    output din,
    output inject,
    input  dout,
    input  data_ready,
    input  busy,
    input  init_done,
    input  cmd_err
  );

  modport slave (
    input  rd,
    input  wr,
    input  refresh,
    input  addr,
    input  din,
    input  inject,
    output dout,
    output data_ready,
    output busy,
    output init_done,
    output cmd_err
  );

endinterface

// File: rtl/ddr3_ctrl_bram_model_bram.sv
// Single-port RAM, synchronous write, registered read.
// No reset on storage or output so it maps onto block RAM.
module ddr3_bram_sp #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (en) q <= mem[addr];
  end

endmodule

// File: rtl/ddr3_ctrl_bram_model.sv
// DDR3 controller user-interface responder backed by block RAM.
// FSM with busy counter, read pipeline and read-error injection.
module ddr3_ctrl_bram_model
  import ddr3_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int WRITE_BUSY   = 2,
  parameter int REFRESH_BUSY = 6,
  parameter int INIT_CYCLES  = 16
) (
  input logic                 clk,
  input logic                 resetn,
  ddr3_ctrl_bram_model_if.slave bus
);

  localparam int MAXC = max4(INIT_CYCLES, WRITE_BUSY,
                             READ_LATENCY, REFRESH_BUSY);
  localparam int CW   = $clog2(MAXC + 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  cmd_t                   cmd;
  logic                   any_cmd;
  logic                   collide;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [DDR3_DATA_W-1:0] mask_q;
  logic [DDR3_DATA_W-1:0] ram_q;
  logic [DDR3_DATA_W-1:0] dout_q;
  logic                   busy_q;
  logic                   ready_q;
  logic                   init_q;
  logic                   err_q;
  logic                   ram_we;
  logic                   ram_en;
  logic                   unused_addr;

  assign cmd = '{
    rd:      bus.rd,
    wr:      bus.wr,
    refresh: bus.refresh
  };

  assign any_cmd = |cmd;
  assign collide = (cmd.rd & cmd.wr)
                 | (cmd.rd & cmd.refresh)
                 | (cmd.wr & cmd.refresh);

  // Write commits on the accept edge; read address is
  // registered and the RAM is read one edge later.
  assign ram_we   = resetn && state == IDLE && cmd.wr;
  assign ram_en   = resetn && state == READ
                 && cnt == CW'(1);
  assign ram_addr = ram_we ? bus.addr[ADDR_WIDTH-1:0]
                           : addr_q;

  assign unused_addr = ^bus.addr[DDR3_ADDR_W-1:ADDR_WIDTH];

  ddr3_bram_sp #(
    .AW (ADDR_WIDTH),
    .DW (DDR3_DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (bus.din),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= INIT;
      cnt     <= '0;
      busy_q  <= 1'b1;
      init_q  <= 1'b0;
      ready_q <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      if (state != IDLE && any_cmd) err_q <= 1'b1;
      case (state)
        INIT: begin
          if (cnt == CW'(INIT_CYCLES - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            init_q <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (collide) err_q <= 1'b1;
          priority case (1'b1)
            cmd.wr: begin
              state  <= WRITE;
              busy_q <= 1'b1;
              cnt    <= CW'(1);
            end
            cmd.rd: begin
              state  <= READ;
              busy_q <= 1'b1;
              cnt    <= CW'(1);
              addr_q <= bus.addr[ADDR_WIDTH-1:0];
              mask_q <= inj_mask(bus.inject);
            end
            cmd.refresh: begin
              state  <= REFRESH;
              busy_q <= 1'b1;
              cnt    <= CW'(1);
            end
            default: ;
          endcase
        end
        WRITE: begin
          if (cnt == CW'(WRITE_BUSY)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        READ: begin
          if (cnt == CW'(READ_LATENCY)) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            dout_q  <= ram_q ^ mask_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REFRESH: begin
          if (cnt == CW'(REFRESH_BUSY)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= INIT;
          cnt    <= '0;
          busy_q <= 1'b1;
          init_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.data_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.init_done  = init_q;
  assign bus.cmd_err    = err_q;

endmodule

// File: tb/tb_ddr3_ctrl_bram_model.sv
// Directed bench for the BRAM-backed DDR3 controller model.
// Vector table for write/read pairs plus hand-built corner sequences.
module tb_ddr3_ctrl_bram_model;
  import ddr3_pkg::*;

  localparam int RL = 2;
  localparam int WB = 2;
  localparam int RB = 6;
  localparam int IC = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  ddr3_ctrl_bram_model_if bus();

  ddr3_ctrl_bram_model #(
    .ADDR_WIDTH   (16),
    .READ_LATENCY (RL),
    .WRITE_BUSY   (WB),
    .REFRESH_BUSY (RB),
    .INIT_CYCLES  (IC)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [25:0] waddr;
    logic [25:0] raddr;
    logic [15:0] din;
    logic [1:0]  inj;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.refresh = 1'b0;
    bus.inject  = 2'b00;
  endtask

  task automatic wait_free(input string nm);
    int i;
    i = 0;
    while (bus.busy && i < 40) begin
      tick();
      i++;
    end
    chk({nm, " free"}, {31'b0, bus.busy}, 0);
  endtask

  task automatic do_reset();
    idle_bus();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (IC) tick();
  endtask

  task automatic do_write(
    input logic [25:0] a,
    input logic [15:0] d
  );
    bus.addr = a;
    bus.din  = d;
    bus.wr   = 1'b1;
    tick();
    bus.wr = 1'b0;
    wait_free("wr");
  endtask

  task automatic do_read(
    input  logic [25:0] a,
    input  logic [1:0]  inj,
    output logic [15:0] d,
    output int          lat
  );
    bus.addr   = a;
    bus.inject = inj;
    bus.rd     = 1'b1;
    tick();
    bus.rd     = 1'b0;
    bus.inject = 2'b00;
    lat = 0;
    while (!bus.data_ready && lat < 20) begin
      tick();
      lat++;
    end
    d = bus.dout;
  endtask

  initial begin
    logic [15:0] d;
    int lat;
    logic seen;

    vecs[0] = '{26'h0000005, 26'h0000005, 16'h67B9, 2'b00, 16'h67B9};
    vecs[1] = '{26'h0010003, 26'h0000003, 16'hA5A5, 2'b00, 16'hA5A5};
    vecs[2] = '{26'h0000020, 26'h0000020, 16'h1234, 2'b10, 16'h1334};
    vecs[3] = '{26'h0000020, 26'h0000020, 16'h1234, 2'b00, 16'h1234};
    vecs[4] = '{26'h3FFFFFF, 26'h000FFFF, 16'hBEEF, 2'b11, 16'hBFEE};
    vecs[5] = '{26'h0000000, 26'h0000000, 16'h0000, 2'b11, 16'h0101};

    idle_bus();
    bus.addr = '0;
    bus.din  = '0;

    // init window with a read dropped at cycle 5
    resetn = 1'b0;
    tick();
    chk("rst busy", {31'b0, bus.busy}, 1);
    chk("rst init_done", {31'b0, bus.init_done}, 0);
    chk("rst data_ready", {31'b0, bus.data_ready}, 0);
    chk("rst dout", {16'b0, bus.dout}, 0);
    chk("rst cmd_err", {31'b0, bus.cmd_err}, 0);
    resetn = 1'b1;
    for (int k = 1; k <= IC; k++) begin
      bus.rd = (k == 5);
      tick();
      if (k == IC - 1) begin
        chk("init busy", {31'b0, bus.busy}, 1);
        chk("init not done", {31'b0, bus.init_done}, 0);
      end
    end
    bus.rd = 1'b0;
    chk("init busy low", {31'b0, bus.busy}, 0);
    chk("init_done", {31'b0, bus.init_done}, 1);
    chk("init cmd_err", {31'b0, bus.cmd_err}, 1);
    chk("init no read", {31'b0, bus.data_ready}, 0);

    do_reset();
    chk("reinit cmd_err", {31'b0, bus.cmd_err}, 0);

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].waddr, vecs[i].din);
      do_read(vecs[i].raddr, vecs[i].inj, d, lat);
      chk($sformatf("v%0d dout", i), {16'b0, d}, {16'b0, vecs[i].exp});
      chk($sformatf("v%0d lat", i), lat, RL);
      chk($sformatf("v%0d busy", i), {31'b0, bus.busy}, 0);
      tick();
      chk($sformatf("v%0d pulse", i), {31'b0, bus.data_ready}, 0);
      chk($sformatf("v%0d hold", i), {16'b0, bus.dout}, {16'b0, vecs[i].exp});
    end
    chk("clean cmd_err", {31'b0, bus.cmd_err}, 0);

    do_write(26'h0000040, 16'h5555);
    chk("dout held over wr", {16'b0, bus.dout}, 32'h0101);

    // rd+wr collision: write wins, read dropped
    bus.addr = 26'h0000010;
    bus.din  = 16'h1111;
    bus.rd   = 1'b1;
    bus.wr   = 1'b1;
    tick();
    idle_bus();
    chk("coll busy", {31'b0, bus.busy}, 1);
    chk("coll cmd_err", {31'b0, bus.cmd_err}, 1);
    tick();
    chk("coll busy n+1", {31'b0, bus.busy}, 1);
    chk("coll no ready1", {31'b0, bus.data_ready}, 0);
    tick();
    chk("coll busy n+2", {31'b0, bus.busy}, 0);
    chk("coll no ready2", {31'b0, bus.data_ready}, 0);
    do_read(26'h0000010, 2'b00, d, lat);
    chk("coll mem", {16'b0, d}, 32'h1111);

    // refresh busy window, write inside it dropped
    do_reset();
    bus.refresh = 1'b1;
    tick();
    bus.refresh = 1'b0;
    for (int k = 1; k < RB; k++) begin
      if (k == 3) begin
        bus.wr   = 1'b1;
        bus.addr = 26'h0000020;
        bus.din  = 16'hDEAD;
      end
      tick();
      bus.wr = 1'b0;
      if (k == RB - 1)
        chk("ref busy last", {31'b0, bus.busy}, 1);
    end
    tick();
    chk("ref busy low", {31'b0, bus.busy}, 0);
    chk("ref cmd_err", {31'b0, bus.cmd_err}, 1);
    do_read(26'h0000020, 2'b00, d, lat);
    chk("ref mem intact", {16'b0, d}, 32'h1234);

    // reset during a read aborts it
    tick();
    bus.addr = 26'h0000005;
    bus.rd   = 1'b1;
    tick();
    bus.rd = 1'b0;
    resetn = 1'b0;
    tick();
    chk("mid rst ready", {31'b0, bus.data_ready}, 0);
    chk("mid rst busy", {31'b0, bus.busy}, 1);
    chk("mid rst dout", {16'b0, bus.dout}, 0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < IC; k++) begin
      tick();
      if (bus.data_ready) seen = 1'b1;
    end
    chk("mid rst no ready", {31'b0, seen}, 0);
    chk("mid rst init", {31'b0, bus.init_done}, 1);
    do_read(26'h0000005, 2'b00, d, lat);
    chk("keep mem5", {16'b0, d}, 32'h67B9);
    do_read(26'h0010003, 2'b00, d, lat);
    chk("keep alias3", {16'b0, d}, 32'hA5A5);
    do_read(26'h000FFFF, 2'b00, d, lat);
    chk("keep ffff", {16'b0, d}, 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
